// File: rtl/lcd_frame_scanner.sv
// Streams a finished 8x8 image from the synchronous result buffer to the panel
// in row-major order over valid/ready, with line/frame markers and a 2-entry skid FIFO.
module lcd_frame_scanner #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int DW    = 8,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          mem_cen,
   output logic [AW-1:0] mem_a,
   input  logic [DW-1:0] mem_q,
   output logic [DW-1:0] pix_data,
   output logic          pix_valid,
   input  logic          pix_ready,
   output logic          pix_sol,
   output logic          pix_eol,
   output logic          pix_sof,
   output logic          pix_eof,
   output logic          frame_done
);

   localparam logic [AW-1:0] LAST_A = AW'(IMG_W * IMG_H - 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] rd_addr, a_hold, infl_a, head_a;
   logic          infl, issue, pop;
   logic [DW-1:0] fd [2];
   logic [AW-1:0] fa [2];
   logic          wp, rp;
   logic [1:0]    cnt;
   logic [2:0]    occ;

   assign pix_valid = (cnt != 2'd0);
   assign pop       = pix_valid & pix_ready;
   assign head_a    = fa[rp];

   // Occupancy credits the pop happening this cycle so a steady ready sustains 1 pixel/clk.
   assign occ   = 3'(cnt) + 3'(infl) - 3'(pop);
   assign issue = (state == S_FETCH) && (occ < 3'd2);

   assign mem_cen = ~issue;
   assign mem_a   = issue ? rd_addr : a_hold;

   assign pix_data = pix_valid ? fd[rp] : '0;
   assign pix_sol  = pix_valid && ((int'(head_a) % IMG_W) == 0);
   assign pix_eol  = pix_valid && ((int'(head_a) % IMG_W) == IMG_W - 1);
   assign pix_sof  = pix_valid && (head_a == '0);
   assign pix_eof  = pix_valid && (head_a == LAST_A);

   always_comb begin
      state_nx   = state;
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         S_IDLE:  if (start) state_nx = S_FETCH;
         S_FETCH: begin
            busy = 1'b1;
            if (issue && rd_addr == LAST_A) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (pop && head_a == LAST_A) state_nx = S_DONE;
         end
         S_DONE: begin
            frame_done = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_addr <= '0;
         a_hold  <= '0;
         infl    <= 1'b0;
         infl_a  <= '0;
         wp      <= 1'b0;
         rp      <= 1'b0;
         cnt     <= '0;
         for (int unsigned i = 0; i < 2; i++) begin
            fd[i] <= '0;
            fa[i] <= '0;
         end
      end else begin
         if (state == S_IDLE && start) rd_addr <= '0;
         if (issue) begin
            rd_addr <= rd_addr + AW'(1);
            a_hold  <= rd_addr;
         end
         infl   <= issue;
         infl_a <= rd_addr;
         if (infl) begin
            fd[wp] <= mem_q;
            fa[wp] <= infl_a;
            wp     <= ~wp;
         end
         if (pop) rp <= ~rp;
         cnt <= cnt + 2'(infl) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Directed/randomized bench for lcd_frame_scanner: a buffer model feeds the DUT and each
// frame is compared against the expected row-major pixel stream with derived markers.
module tb_lcd_frame_scanner;

   localparam int DW = 8;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          reset, start, pix_ready;
   logic          busy, mem_cen, pix_valid, pix_sol, pix_eol, pix_sof, pix_eof, frame_done;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_q, pix_data;
   logic [DW-1:0] mem [64];

   int n_assert = 0;
   int n_fail   = 0;

   lcd_frame_scanner #(.IMG_W(8), .IMG_H(8), .DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .mem_cen(mem_cen),
      .mem_a(mem_a), .mem_q(mem_q), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_sol(pix_sol), .pix_eol(pix_eol), .pix_sof(pix_sof),
      .pix_eof(pix_eof), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!mem_cen) mem_q <= mem[mem_a];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_cen"}, 32'(mem_cen), 32'd1);
      chk({tag, "_mem_a"}, 32'(mem_a), 32'd0);
      chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
      chk({tag, "_data"}, 32'(pix_data), 32'd0);
      chk({tag, "_markers"}, 32'({pix_sol, pix_eol, pix_sof, pix_eof}), 32'd0);
      chk({tag, "_done"}, 32'(frame_done), 32'd0);
   endtask

   // mode 0: ready high; 1: 1010 toggle plus 20-cycle stall at address 30; 2: random ready
   task automatic frame(input int mode, input bit pulses, input bit timing, input int abort_at);
      int   cyc = 0, idx = 0, issued = 0, acc_cyc = -1, first_v = -1;
      int   n_sol = 0, n_eol = 0, burst = -1;
      bit   r, p10 = 0, done = 0, aborted = 0, prev_stall = 0, pop;
      logic [DW+3:0] cur, prev, exp;
      prev = '0;
      @(negedge clk);
      start = 1'b1;
      while (!done && !aborted && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         case (mode)
            0: r = 1'b1;
            1: begin
               if (idx == 30 && burst < 0) burst = 20;
               if (burst > 0) begin r = 1'b0; burst--; end
               else r = cyc[0];
            end
            default: r = 1'($urandom_range(0, 1));
         endcase
         pix_ready = r;
         #1;
         if (abort_at >= 0 && idx == abort_at) begin
            reset = 1'b0;
            #1;
            chk_reset_outputs("async_reset");
            aborted = 1;
         end else begin
            pop = pix_valid && r;
            chk("frame_done", 32'(frame_done), 32'(acc_cyc >= 0 && cyc == acc_cyc + 1));
            chk("busy", 32'(busy), 32'(!(acc_cyc >= 0 && cyc == acc_cyc + 1)));
            if (!mem_cen) begin
               chk("issue_rule", 32'((issued - idx - int'(pop)) < 2), 32'd1);
               chk("mem_a", 32'(mem_a), 32'(issued));
               issued++;
            end else if (issued > 0) begin
               chk("mem_a_hold", 32'(mem_a), 32'(issued - 1));
            end
            if (pix_valid && first_v < 0) first_v = cyc;
            cur = {pix_data, pix_sol, pix_eol, pix_sof, pix_eof};
            if (pix_valid) begin
               if (prev_stall) chk("stall_stable", 32'(cur), 32'(prev));
               if (r) begin
                  if (idx >= 64) chk("extra_pixel", 32'd1, 32'd0);
                  else begin
                     exp = {mem[idx], idx % 8 == 0, idx % 8 == 7, idx == 0, idx == 63};
                     chk($sformatf("pix%0d", idx), 32'(cur), 32'(exp));
                  end
                  n_sol += int'(pix_sol);
                  n_eol += int'(pix_eol);
                  idx++;
                  if (idx == 64) acc_cyc = cyc;
               end
            end
            prev_stall = pix_valid && !r;
            prev = cur;
            if (pulses && idx == 10 && !p10) begin start = 1'b1; p10 = 1; end
            if (frame_done) begin
               done = 1;
               if (pulses) start = 1'b1;
            end
            if (acc_cyc >= 0 && cyc > acc_cyc + 3) break;
         end
      end
      if (!aborted) begin
         chk("frame_finished", 32'(done), 32'd1);
         chk("pix_count", 32'(idx), 32'd64);
         chk("sol_count", 32'(n_sol), 32'd8);
         chk("eol_count", 32'(n_eol), 32'd8);
         chk("read_count", 32'(issued), 32'd64);
         if (timing) begin
            chk("first_valid_cycle", 32'(first_v), 32'd3);
            chk("done_cycle", 32'(acc_cyc + 1), 32'd67);
         end
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_cen", 32'(mem_cen), 32'd1);
            chk("idle_valid", 32'(pix_valid), 32'd0);
         end
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; pix_ready = 1'b0;
      void'($urandom(32'd20240611));
      for (int k = 0; k < 64; k++) mem[k] = 8'(k);
      repeat (2) @(negedge clk);
      chk_reset_outputs("por");
      reset = 1'b1;

      // ramp image, full rate, latency checks
      frame(0, 1'b0, 1'b1, -1);
      // random image, toggling ready with long stall
      for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
      frame(1, 1'b0, 1'b0, -1);
      // spurious starts mid-frame and in DONE, then a clean second frame
      frame(0, 1'b1, 1'b0, -1);
      frame(0, 1'b0, 1'b1, -1);
      // asynchronous reset at pixel 40, then full frame from address 0
      for (int k = 0; k < 64; k++) mem[k] = 8'(k);
      frame(0, 1'b0, 1'b0, 40);
      repeat (2) @(negedge clk);
      chk_reset_outputs("in_reset");
      reset = 1'b1;
      frame(0, 1'b0, 1'b1, -1);
      // checkerboard with random ready
      for (int k = 0; k < 64; k++) mem[k] = (((k / 8) + (k % 8)) % 2 == 1) ? 8'hFF : 8'h00;
      frame(2, 1'b0, 1'b0, -1);
      frame(2, 1'b1, 1'b0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
